// File: rtl/bp_fe_icache_rolly_shim.sv
// Rolly-FIFO request driver feeding the bp_fe_icache TL/TV pipeline with in-order commit and replay on miss.
// Optional statistics counters are built when BP_FE_ICACHE_SHIM_STATS_EN is defined.
module bp_fe_icache_rolly_shim #(
   parameter int unsigned vaddr_width_p = 39,
   parameter int unsigned ptag_width_p  = 28,
   parameter int unsigned instr_width_p = 32,
   parameter int unsigned els_p         = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_i,

   input  logic [vaddr_width_p-1:0] req_vaddr_i,
   input  logic [ptag_width_p-1:0]  req_ptag_i,
   input  logic                     req_uncached_i,
   input  logic                     req_v_i,
   output logic                     req_ready_o,

   output logic [vaddr_width_p-1:0] cache_vaddr_o,
   output logic                     cache_v_o,
   input  logic                     cache_yumi_i,
   output logic [ptag_width_p-1:0]  cache_ptag_o,
   output logic                     cache_ptag_v_o,
   output logic                     cache_ptag_uncached_o,
   output logic                     cache_poison_o,

   input  logic [vaddr_width_p-1:0] cache_vaddr_i,
   input  logic [instr_width_p-1:0] cache_data_i,
   input  logic                     cache_data_v_i,
   input  logic                     cache_miss_not_data_i,
   output logic                     cache_data_yumi_o,

   output logic [vaddr_width_p-1:0] resp_vaddr_o,
   output logic [instr_width_p-1:0] resp_data_o,
   output logic                     resp_v_o,
   input  logic                     resp_ready_i,

   output logic                     error_o,
   output logic [31:0]              stat_hit_o,
   output logic [31:0]              stat_replay_o
);

   localparam int unsigned LG = $clog2(els_p);
   localparam int unsigned AW = LG + 1;

   typedef enum logic {S_RUN, S_ROLLBACK} state_e;

   state_e r_state, w_state_nxt;

   logic [AW-1:0]            r_wptr, r_rptr, r_cptr;
   logic [vaddr_width_p-1:0] r_vaddr_mem [els_p];
   logic [ptag_width_p-1:0]  r_ptag_mem  [els_p];
   logic [els_p-1:0]         r_unc_mem;

   logic [ptag_width_p-1:0]  r_ptag;
   logic                     r_ptag_unc;
   logic                     r_ptag_v;
   logic                     r_error;

   logic [AW-1:0]            w_count;
   logic                     w_full;
   logic                     w_push;
   logic                     w_miss;
   logic                     w_hit;
   logic                     w_issue;
   logic                     w_commit;
   logic                     w_has_pending;
   logic [LG-1:0]            w_widx, w_ridx, w_cidx;

   assign w_widx        = r_wptr[LG-1:0];
   assign w_ridx        = r_rptr[LG-1:0];
   assign w_cidx        = r_cptr[LG-1:0];
   assign w_count       = r_wptr - r_cptr;
   assign w_full        = (w_count == AW'(els_p));
   assign w_push        = req_v_i & ~w_full;
   assign w_miss        = cache_data_v_i & cache_miss_not_data_i;
   assign w_hit         = cache_data_v_i & ~cache_miss_not_data_i;
   assign w_has_pending = (r_cptr != r_wptr);
   assign w_issue       = cache_v_o & cache_yumi_i;
   assign w_commit      = w_hit & resp_ready_i & w_has_pending;

   // Next-state and all handshake outputs; a miss suppresses issue so yumi can never coincide with it.
   always_comb begin
      w_state_nxt       = r_state;
      cache_v_o         = 1'b0;
      cache_vaddr_o     = '0;
      cache_poison_o    = 1'b0;
      cache_data_yumi_o = 1'b0;
      resp_v_o          = 1'b0;
      resp_vaddr_o      = '0;
      resp_data_o       = '0;

      case (r_state)
         S_RUN: begin
            cache_v_o = (r_rptr != r_wptr) & ~w_miss;
            if (w_miss) begin
               w_state_nxt = S_ROLLBACK;
            end
         end
         S_ROLLBACK: begin
            w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_RUN;
      endcase

      if (cache_v_o) begin
         cache_vaddr_o = r_vaddr_mem[w_ridx];
      end

      if (w_miss) begin
         cache_poison_o    = 1'b1;
         cache_data_yumi_o = 1'b1;
      end else if (w_hit) begin
         resp_v_o          = 1'b1;
         resp_vaddr_o      = r_vaddr_mem[w_cidx];
         resp_data_o       = cache_data_i;
         cache_data_yumi_o = resp_ready_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Rollback rewinds the issue pointer to the oldest uncommitted entry so it replays in order.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cptr <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_miss) begin
            r_rptr <= r_cptr;
         end else if (w_issue) begin
            r_rptr <= r_rptr + AW'(1);
         end
         if (w_commit) begin
            r_cptr <= r_cptr + AW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_vaddr_mem[w_widx] <= req_vaddr_i;
         r_ptag_mem[w_widx]  <= req_ptag_i;
         r_unc_mem[w_widx]   <= req_uncached_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_ptag     <= '0;
         r_ptag_unc <= 1'b0;
         r_ptag_v   <= 1'b0;
      end else begin
         r_ptag_v <= w_issue & ~w_miss;
         if (w_issue) begin
            r_ptag     <= r_ptag_mem[w_ridx];
            r_ptag_unc <= r_unc_mem[w_ridx];
         end
      end
   end

   assign cache_ptag_v_o        = r_ptag_v;
   assign cache_ptag_o          = r_ptag_v ? r_ptag : '0;
   assign cache_ptag_uncached_o = r_ptag_v & r_ptag_unc;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_error <= 1'b0;
      end else if (w_hit && w_has_pending && (cache_vaddr_i != r_vaddr_mem[w_cidx])) begin
         r_error <= 1'b1;
      end
   end

   assign req_ready_o = ~w_full;
   assign error_o     = r_error;

`ifdef BP_FE_ICACHE_SHIM_STATS_EN
   logic [31:0] r_stat_hit;
   logic [31:0] r_stat_replay;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_stat_hit    <= '0;
         r_stat_replay <= '0;
      end else begin
         if (w_commit && (r_stat_hit != '1)) begin
            r_stat_hit <= r_stat_hit + 32'd1;
         end
         if (w_miss && (r_stat_replay != '1)) begin
            r_stat_replay <= r_stat_replay + 32'd1;
         end
      end
   end

   assign stat_hit_o    = r_stat_hit;
   assign stat_replay_o = r_stat_replay;
`else
   assign stat_hit_o    = '0;
   assign stat_replay_o = '0;
`endif

endmodule
